// File: rtl/avl_bram_slave_if.sv
// avl_bram_slave_if: Avalon-MM burst bus between an ldst master and the BRAM slave.
// Master drives address/read/write/writedata/byteenable/burstcount.
// Slave drives waitrequest/readdata/readdatavalid/err.
interface avl_bram_slave_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 11
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                err;
  modport master (
    output address, read, write, writedata, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid, err
  );
  modport slave (
    input  address, read, write, writedata, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid, err
  );
endinterface

// File: rtl/avl_bram_slave.sv
// avl_bram_slave: Avalon-MM burst slave backed by a 2^DEPTH_W x DATA_W on-chip memory.
// Ports: clk, rst_n (sync, active-low), bus (avl_bram_slave_if.slave).
// Writes commit with zero wait states; read bursts stall the bus and stream one beat per cycle.
module avl_bram_slave #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 12,
  parameter int BURST_W = 11
) (
  input logic clk,
  input logic rst_n,
  avl_bram_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [2**DEPTH_W];
  logic [DEPTH_W-1:0] idx, ptr, wa;
  logic [BURST_W-1:0] rem;
  logic bc_ok, last, we, re, err_set, unused_addr;
  assign idx = bus.address[DEPTH_W+3:4];
  assign unused_addr = ^{bus.address[ADDR_W-1:DEPTH_W+4], bus.address[3:0]};
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.write && bc_ok ? (bus.burstcount == BURST_W'(1) ? IDLE : WBURST)
                                                   : (bus.read && bc_ok ? RBURST : IDLE))
             : state == WBURST ? (bus.write && last ? IDLE : WBURST)
             : (last ? IDLE : RBURST);
  end
  // A simultaneous read+write in IDLE lets the write win; the read only raises err.
  always_comb begin
    bc_ok = bus.burstcount != '0;
    last = rem == BURST_W'(1);
    bus.waitrequest = state == RBURST;
    we = bus.write && (state == WBURST || (state == IDLE && bc_ok));
    wa = state == WBURST ? ptr : idx;
    re = state == RBURST;
    err_set = state == IDLE ? (bus.read || bus.write) && (!bc_ok || (bus.read && bus.write))
                            : state == WBURST && bus.read;
  end
  // ptr is the next word to touch for either burst kind; it wraps modulo the depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      ptr <= '0;
      bus.err <= 1'b0;
      bus.readdatavalid <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (state == IDLE && bc_ok && (bus.read || bus.write)) begin
        rem <= bus.write ? bus.burstcount - BURST_W'(1) : bus.burstcount;
        ptr <= bus.write ? idx + DEPTH_W'(1) : idx;
      end else if (we || re) begin
        rem <= rem - BURST_W'(1);
        ptr <= ptr + DEPTH_W'(1);
      end
      bus.err <= bus.err | err_set;
      bus.readdatavalid <= re;
      if (re) bus.readdata <= mem[ptr];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++)
      if (we && bus.byteenable[i]) mem[wa][8*i +: 8] <= bus.writedata[8*i +: 8];
  end
endmodule

// File: tb/tb_avl_bram_slave.sv
// tb_avl_bram_slave: directed self-checking bench for avl_bram_slave.
module tb_avl_bram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q [$];
  localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  avl_bram_slave_if bus ();
  avl_bram_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input int n, input logic [127:0] base,
                    input logic [15:0] be, input int gap_at, input int gaps);
    for (int i = 0; i < n; i++) begin
      bus.address = a;
      bus.burstcount = 11'(n);
      bus.write = 1'b1;
      bus.writedata = base + 128'(i);
      bus.byteenable = be;
      chk("wr_wait", bus.waitrequest, 0);
      step();
      bus.write = 1'b0;
      if (i == gap_at) repeat (gaps) step();
    end
  endtask
  task automatic rd(input logic [31:0] a, input int n);
    bus.address = a;
    bus.read = 1'b1;
    bus.burstcount = 11'(n);
    chk("rd_accept", bus.waitrequest, 0);
    step();
    bus.read = 1'b0;
    for (int j = 0; j <= n + 1; j++) begin
      chk("rd_wait", bus.waitrequest, 128'(j < n));
      chk("rd_valid", bus.readdatavalid, 128'(j >= 1 && j <= n));
      if (j >= 1 && j <= n) chk("rd_data", bus.readdata, exp_q[j-1]);
      step();
    end
    exp_q.delete();
  endtask
  initial begin
    bus.address = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    bus.byteenable = '1;
    bus.burstcount = 11'd1;
    repeat (3) step();
    chk("rst_wait", bus.waitrequest, 0);
    chk("rst_valid", bus.readdatavalid, 0);
    chk("rst_data", bus.readdata, 0);
    chk("rst_err", bus.err, 0);
    rst_n = 1'b1;
    step();
    wr(32'h40, 1, D0, 16'hFFFF, -1, 0);
    exp_q = '{D0};
    rd(32'h40, 1);
    wr(32'h100, 8, 128'h0, 16'hFFFF, 3, 2);
    exp_q = '{128'd0, 128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7};
    rd(32'h100, 8);
    chk("burst_err", bus.err, 0);
    wr(32'h50, 1, '1, 16'hFFFF, -1, 0);
    wr(32'h50, 1, '0, 16'h00F0, -1, 0);
    exp_q = '{{64'hFFFFFFFF_FFFFFFFF, 32'h0, 32'hFFFFFFFF}};
    rd(32'h50, 1);
    wr(32'hFFE0, 4, 128'hA0, 16'hFFFF, -1, 0);
    exp_q = '{128'hA0, 128'hA1, 128'hA2, 128'hA3};
    rd(32'hFFE0, 4);
    exp_q = '{128'hA2};
    rd(32'h0, 1);
    exp_q = '{128'hA3};
    rd(32'h10, 1);
    bus.address = 32'h40;
    bus.burstcount = 11'd0;
    bus.write = 1'b1;
    bus.writedata = 128'hDEAD;
    step();
    bus.write = 1'b0;
    chk("bc0_wr_err", bus.err, 1);
    chk("bc0_wr_valid", bus.readdatavalid, 0);
    bus.read = 1'b1;
    chk("bc0_rd_accept", bus.waitrequest, 0);
    step();
    bus.read = 1'b0;
    chk("bc0_rd_wait", bus.waitrequest, 0);
    step();
    chk("bc0_rd_valid", bus.readdatavalid, 0);
    exp_q = '{D0};
    rd(32'h40, 1);
    bus.address = 32'h60;
    bus.burstcount = 11'd1;
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.writedata = 128'hBEEF;
    bus.byteenable = '1;
    step();
    bus.read = 1'b0;
    bus.write = 1'b0;
    chk("rw_wait", bus.waitrequest, 0);
    chk("rw_err", bus.err, 1);
    step();
    chk("rw_valid", bus.readdatavalid, 0);
    exp_q = '{128'hBEEF};
    rd(32'h60, 1);
    rst_n = 1'b0;
    step();
    chk("rst2_err", bus.err, 0);
    rst_n = 1'b1;
    step();
    bus.address = 32'h300;
    bus.burstcount = 11'd2;
    bus.write = 1'b1;
    bus.writedata = 128'h55;
    step();
    chk("wb_err0", bus.err, 0);
    bus.read = 1'b1;
    bus.writedata = 128'h66;
    step();
    bus.read = 1'b0;
    bus.write = 1'b0;
    chk("wb_rd_err", bus.err, 1);
    exp_q = '{128'h55, 128'h66};
    rd(32'h300, 2);
    wr(32'h200, 16, 128'h100, 16'hFFFF, -1, 0);
    bus.address = 32'h200;
    bus.burstcount = 11'd16;
    bus.read = 1'b1;
    step();
    bus.read = 1'b0;
    repeat (3) step();
    chk("mid_valid", bus.readdatavalid, 1);
    chk("mid_data", bus.readdata, 128'h102);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", bus.readdatavalid, 0);
    chk("mid_rst_wait", bus.waitrequest, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", bus.readdatavalid, 0);
    chk("post_rst_wait", bus.waitrequest, 0);
    exp_q = '{D0};
    rd(32'h40, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avl_bram_slave.md
# avl_bram_slave

Avalon-MM burst slave backed by an on-chip 128-bit memory, acting as the responder that `rf_ldst` (through its `sdram_intf` ldst port) talks to when no external SDRAM controller is present. It accepts single and burst reads/writes, returns read beats on `readdatavalid`, and applies `waitrequest` back-pressure while a read burst drains. It is used as the SDRAM stand-in for block-level simulation and small FPGA builds of the register-file path.

## Interface
- `DATA_W`, 128, Avalon data width; the memory word is the same width.
- `ADDR_W`, 32, Avalon byte-address width.
- `DEPTH_W`, 12, log2 of memory depth in words (4096 words).
- `BURST_W`, 11, `burstcount` width.
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `address`  input  ADDR_W  byte address; word index = `address[DEPTH_W+3:4]`; bits [3:0] ignored.
- `read`  input  1  read command.
- `write`  input  1  write command or write data beat.
- `writedata`  input  DATA_W  write beat data.
- `byteenable`  input  DATA_W/8  per-byte write enable; ignored on reads.
- `burstcount`  input  BURST_W  beats in the burst; sampled only on command acceptance.
- `waitrequest`  output  1  slave cannot accept a command or beat this cycle.
- `readdata`  output  DATA_W  read beat data.
- `readdatavalid`  output  1  `readdata` valid this cycle.
- `err`  output  1  sticky protocol-error flag; cleared only by reset.

## Operation
- FSM states: IDLE, WBURST, RBURST. Reset → IDLE.
- Accept condition: (`read` or `write`) && !`waitrequest`.
- `waitrequest` is combinational from state: 1 in RBURST, 0 in IDLE and WBURST.
- IDLE, `write` and `burstcount` ≥ 1: beat 0 is written at word W = address index, with per-byte enables. If `burstcount` == 1, stay in IDLE. Otherwise go to WBURST with remaining = `burstcount`-1 and next = W+1.
- WBURST: each cycle with `write`=1 writes one beat at next, increments next and decrements remaining. Cycles with `write`=0 are bubbles with no effect. When the final beat is written, return to IDLE. `address` and `burstcount` are ignored in WBURST.
- IDLE, `read` and `burstcount` ≥ 1: latch W and N=`burstcount`, then go to RBURST. In RBURST one memory read is issued per cycle at W, W+1, … W+N-1. Memory read latency is 1 cycle, and data is presented registered with `readdatavalid`.
- Word index increments modulo 2^DEPTH_W: burst from word 4095 wraps to word 0.
- Error cases. Each sets `err`, and the offending input is otherwise ignored:
  - `burstcount` == 0 on a command in IDLE: command dropped, state unchanged.
  - `read` and `write` both high in IDLE: the write is executed, the read is dropped.
  - `read` high in WBURST: read dropped, write handling unaffected.
- Memory contents are not reset. Reset mid-burst returns the FSM to IDLE, cancels remaining beats and drives `readdatavalid` to 0. Words already written remain.
- Reset values: `readdatavalid`=0, `readdata`=0, `err`=0, `waitrequest`=0 (IDLE).

## Timing
- Read command accepted at cycle T with burstcount N:
  - memory read for beat k is issued at T+1+k;
  - `readdatavalid` is high with beat k at T+2+k, k=0..N-1, with no gaps;
  - `waitrequest`=1 from T+1 through T+N;
  - state is IDLE at T+N+1, so a new command can be accepted in the same cycle as the last `readdatavalid`.
- Back-to-back single reads: one accepted every 2 cycles; `readdatavalid` every other cycle.
- Writes: zero wait states. A beat presented with `write`=1 in IDLE or WBURST is committed to memory at that clock edge. A read accepted in the cycle after a write's last beat returns the new data.

## Test plan
- Single write of 0x00112233_44556677_8899AABB_CCDDEEFF, all byteenables, to byte address 0x40, then a single read of 0x40: `readdatavalid` exactly 2 cycles after accept, data matches, `waitrequest`=1 for exactly 1 cycle.
- Write burst of 8 beats to 0x100 (data = beat index), with `write` dropped for 2 cycles after beat 3. Then an 8-beat read of 0x100: 8 consecutive valid beats 0..7, `waitrequest` high for 8 cycles, `err`=0.
- Write all-ones to word 5, then write 0 with `byteenable`=16'h00F0: read returns bytes 4–7 zero, all other bytes 0xFF.
- 4-beat write and 4-beat read starting at word 4094 (byte address 0xFFE0): beats land at and return from words 4094, 4095, 0, 1.
- Error injection:
  - command with `burstcount`=0: no memory change, no `readdatavalid`, `err`=1;
  - `read`+`write` together in IDLE: the write is performed, `err` stays 1;
  - after reset, `err`=0.
- Reset asserted at beat 2 of a 16-beat read: `readdatavalid`=0 from the cycle after the reset edge, state IDLE, `waitrequest`=0, and a following single read returns correct data.
